// File: rtl/xor_and_sequencer.sv
// ---------------------------------------------------------------------------
// xor_and_sequencer
//
// Serial frame sequencer for the gated-XOR datapath: out = (a ^ b) & g.
// Each cycle in RUN that is not stalled consumes one operand triple (a, b, g).
// The triple passes through one xor_cell/and_cell pair. The result bit is
// registered and added to a popcount. After WIDTH bits the result is held in
// DONE until the host acknowledges it.
//
// Parameters:
//   WIDTH  bits per frame, 1..15 (fits the 4-bit popcount without overflow)
//
// Ports (standard 8-in/8-out tile):
//   io_in[0]    clock, rising edge
//   io_in[1]    synchronous active-high reset
//   io_in[2]    start   begin a frame (IDLE, or DONE together with ack)
//   io_in[3]    a       operand A bit, LSB first
//   io_in[4]    b       operand B bit, LSB first
//   io_in[5]    g       gate bit
//   io_in[6]    hold    stall, no bit consumed this cycle
//   io_in[7]    ack     host accepts the completed frame
//   io_out[0]   res        registered result bit
//   io_out[1]   bit_valid  res is new this cycle
//   io_out[2]   busy       frame in progress
//   io_out[3]   done       frame complete, result held
//   io_out[7:4] popcount of the current or last frame
//
// Optional feature, macro XOR_AND_SEQ_PARITY_EN:
//   When defined, io_out[7] carries the running parity of the result bits and
//   io_out[6:4] carries popcount modulo 8. When undefined, io_out[7:4] is the
//   full popcount and no parity logic exists.
// ---------------------------------------------------------------------------

module xor_cell (
   input  logic x,
   input  logic y,
   output logic z
);
   assign z = x ^ y;
endmodule

module and_cell (
   input  logic x,
   input  logic y,
   output logic z
);
   assign z = x & y;
endmodule

module xor_and_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   logic clk;
   logic srst;
   logic start;
   logic a;
   logic b;
   logic g;
   logic hold;
   logic ack;

   assign clk   = io_in[0];
   assign srst  = io_in[1];
   assign start = io_in[2];
   assign a     = io_in[3];
   assign b     = io_in[4];
   assign g     = io_in[5];
   assign hold  = io_in[6];
   assign ack   = io_in[7];

   state_t     state_reg;
   logic [3:0] cnt_reg;
   logic [3:0] pop_reg;
   logic       res_reg;
   logic       bit_valid_reg;
   logic       busy_reg;
   logic       done_reg;
`ifdef XOR_AND_SEQ_PARITY_EN
   logic       parity_reg;
`endif

   logic ab_x;
   logic bit_res;

   xor_cell u_xor (.x(a),    .y(b), .z(ab_x));
   and_cell u_and (.x(ab_x), .y(g), .z(bit_res));

   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         pop_reg       <= 4'd0;
         res_reg       <= 1'b0;
         bit_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
`ifdef XOR_AND_SEQ_PARITY_EN
         parity_reg    <= 1'b0;
`endif
      end else begin
         // bit_valid is a one-cycle pulse; only a consumed bit raises it
         bit_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // popcount keeps the previous frame's value until a new start
               if (start) begin
                  state_reg <= RUN;
                  busy_reg  <= 1'b1;
                  cnt_reg   <= 4'd0;
                  pop_reg   <= 4'd0;
`ifdef XOR_AND_SEQ_PARITY_EN
                  parity_reg <= 1'b0;
`endif
               end
            end
            RUN: begin
               if (!hold) begin
                  res_reg       <= bit_res;
                  bit_valid_reg <= 1'b1;
                  cnt_reg       <= cnt_reg + 4'd1;
                  pop_reg       <= pop_reg + {3'd0, bit_res};
`ifdef XOR_AND_SEQ_PARITY_EN
                  parity_reg    <= parity_reg ^ bit_res;
`endif
                  // last bit: done rises on the same edge its result registers
                  if (cnt_reg == LAST_IDX) begin
                     state_reg <= DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end
               end
            end
            DONE: begin
               // start alone is ignored; ack releases, ack+start restarts
               if (ack) begin
                  done_reg <= 1'b0;
                  if (start) begin
                     state_reg <= RUN;
                     busy_reg  <= 1'b1;
                     cnt_reg   <= 4'd0;
                     pop_reg   <= 4'd0;
`ifdef XOR_AND_SEQ_PARITY_EN
                     parity_reg <= 1'b0;
`endif
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

`ifdef XOR_AND_SEQ_PARITY_EN
   assign io_out = {parity_reg, pop_reg[2:0], done_reg, busy_reg, bit_valid_reg, res_reg};
`else
   assign io_out = {pop_reg, done_reg, busy_reg, bit_valid_reg, res_reg};
`endif

endmodule

// File: tb/tb_xor_and_sequencer.sv
// ---------------------------------------------------------------------------
// tb_xor_and_sequencer
//
// Drives a WIDTH=4 and a WIDTH=15 instance from the same input pins. Each
// instance has a frame-level reference model: a list of result bits plus
// idle/running/complete flags. Both outputs are compared against the model
// every cycle. Directed frames add literal expectations, and a long random
// run follows.
// ---------------------------------------------------------------------------

module tb_xor_and_sequencer;

   logic       clk = 1'b0;
   logic [7:1] ctl;
   wire  [7:0] io_in = {ctl, clk};
   logic [7:0] out4;
   logic [7:0] out15;

   always #5 clk = ~clk;

   xor_and_sequencer #(.WIDTH(4))  dut4  (.io_in(io_in), .io_out(out4));
   xor_and_sequencer #(.WIDTH(15)) dut15 (.io_in(io_in), .io_out(out15));

   int checks = 0;
   int errors = 0;

   // frame model per instance: 0 -> WIDTH 4, 1 -> WIDTH 15
   int          m_w [2] = '{4, 15};
   bit          m_act [2];
   bit          m_cmp [2];
   bit          m_res [2];
   bit          m_vld [2];
   int          m_n   [2];
   logic [15:0] m_q   [2];

   function automatic logic [7:1] mk(bit rst, bit st, bit a, bit b, bit g, bit h, bit ak);
      return {ak, h, g, b, a, st, rst};
   endfunction

   task automatic model_step(int i);
      bit rst, st, a, b, g, h, ak, r;
      {ak, h, g, b, a, st, rst} = ctl;
      if (rst) begin
         m_act[i] = 0; m_cmp[i] = 0; m_res[i] = 0; m_vld[i] = 0; m_n[i] = 0; m_q[i] = '0;
      end else begin
         m_vld[i] = 0;
         if (m_act[i]) begin
            if (!h) begin
               r = (a ^ b) & g;
               m_q[i][m_n[i]] = r;
               m_n[i]++;
               m_res[i] = r;
               m_vld[i] = 1;
               if (m_n[i] == m_w[i]) begin
                  m_act[i] = 0;
                  m_cmp[i] = 1;
               end
            end
         end else if (m_cmp[i]) begin
            if (ak) begin
               m_cmp[i] = 0;
               if (st) begin
                  m_act[i] = 1;
                  m_n[i] = 0;
               end
            end
         end else if (st) begin
            m_act[i] = 1;
            m_n[i] = 0;
         end
      end
   endtask

   function automatic logic [7:0] model_out(int i);
      int pop = 0;
      logic [3:0] hi;
      for (int k = 0; k < m_n[i]; k++) pop += int'(m_q[i][k]);
`ifdef XOR_AND_SEQ_PARITY_EN
      hi = {1'(pop % 2), 3'(pop % 8)};
`else
      hi = 4'(pop);
`endif
      return {hi, m_cmp[i], m_act[i], m_vld[i], m_res[i]};
   endfunction

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // one transaction: apply inputs, clock once, compare both instances
   task automatic cycle(logic [7:1] v);
      ctl = v;
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      $display("cyc t=%0t ctl=%b out4=%02h out15=%02h", $time, v, out4, out15);
      check("dut4_model", out4, model_out(0));
      check("dut15_model", out15, model_out(1));
   endtask

   task automatic run_bits(logic [3:0] av, logic [3:0] bv, logic [3:0] gv,
                           logic [3:0] rv, int stall_before);
      for (int k = 0; k < 4; k++) begin
         if (k == stall_before) begin
            for (int s = 0; s < 3; s++) begin
               cycle(mk(0, 0, av[k], bv[k], gv[k], 1, 0));
               check("stall_valid", {7'd0, out4[1]}, 8'd0);
               check("stall_busy", {7'd0, out4[2]}, 8'd1);
            end
         end
         cycle(mk(0, 0, av[k], bv[k], gv[k], 0, 0));
         check("frame_res", {6'd0, out4[1:0]}, {6'd0, 1'b1, rv[k]});
      end
   endtask

   logic [3:0] hi3;
   logic [3:0] hi2;

   initial begin
`ifdef XOR_AND_SEQ_PARITY_EN
      hi3 = 4'hB;
`else
      hi3 = 4'h3;
`endif
      hi2 = 4'h2;
      ctl = mk(1, 0, 0, 0, 0, 0, 0);
      cycle(ctl);
      cycle(ctl);
      check("reset_state", out4, 8'h00);

      // reset in the middle of a frame
      cycle(mk(0, 1, 0, 0, 0, 0, 0));
      cycle(mk(0, 0, 1, 0, 1, 0, 0));
      cycle(mk(0, 0, 1, 0, 1, 0, 0));
      cycle(mk(1, 0, 0, 0, 0, 0, 0));
      check("midframe_reset", out4, 8'h00);

      // full frame: res 1,0,1,1 -> popcount 3
      cycle(mk(0, 1, 0, 0, 0, 0, 0));
      check("start_busy", {7'd0, out4[2]}, 8'd1);
      run_bits(4'b1011, 4'b0110, 4'b1111, 4'b1101, -1);
      check("frame_done", {7'd0, out4[3]}, 8'd1);
      check("frame_pop", {4'd0, out4[7:4]}, {4'd0, hi3});

      // start without ack is ignored
      for (int s = 0; s < 5; s++) begin
         cycle(mk(0, s[0], 0, 0, 0, 0, 0));
         check("noack_hold", {3'd0, out4[7:3]}, {3'd0, hi3, 1'b1});
      end
      cycle(mk(0, 0, 0, 0, 0, 0, 1));
      check("ack_release", {3'd0, out4[7:3]}, {3'd0, hi3, 1'b0});

      // gated frame: res 0,0,1,1 -> popcount 2
      cycle(mk(0, 1, 0, 0, 0, 0, 0));
      run_bits(4'b1011, 4'b0110, 4'b1100, 4'b1100, -1);
      check("gate_pop", {4'd0, out4[7:4]}, {4'd0, hi2});

      // ack+start restarts immediately with cleared counters
      cycle(mk(0, 1, 0, 0, 0, 0, 1));
      check("restart", {4'd0, out4[7:4], out4[3:2]}, 8'b0000_0001);

      // stalled frame: 3 hold cycles before bit 2, same result
      run_bits(4'b1011, 4'b0110, 4'b1111, 4'b1101, 2);
      check("stall_pop", {3'd0, out4[7:3]}, {3'd0, hi3, 1'b1});

      // WIDTH=15 all-ones frame
      cycle(mk(1, 0, 0, 0, 0, 0, 0));
      cycle(mk(0, 1, 0, 0, 0, 0, 0));
      for (int k = 0; k < 15; k++) cycle(mk(0, 0, 1, 0, 1, 0, 0));
      check("w15_pop", {3'd0, out15[7:3]}, {3'd0, 4'hF, 1'b1});

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cycle(mk(($urandom_range(63) == 0), ($urandom_range(3) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(3) == 0), ($urandom_range(3) == 0)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xor_and_sequencer.md
Name: xor_and_sequencer

Overview:
- Frame sequencer for the gated-XOR datapath, computing out = (a XOR b) AND g per bit.
- Accepts serial operand bits on the tile input pins, one bit triple per cycle, for a frame of WIDTH bits.
- Drives each triple through one xor_cell/and_cell pair, registers every result bit, and accumulates a popcount.
- Holds the frame result until the host acknowledges it.
- Drops into a standard 8-in/8-out user tile.

Parameters:
- WIDTH, 4, bits per frame; legal range 1..15.

Ports:
- io_in[0]  input  1  clock; all state on rising edge.
- io_in[1]  input  1  reset; synchronous, active-high.
- io_in[2]  input  1  start: begin a frame.
- io_in[3]  input  1  a: operand A bit, LSB first.
- io_in[4]  input  1  b: operand B bit, LSB first.
- io_in[5]  input  1  g: gate bit for the current position.
- io_in[6]  input  1  hold: stall, no bit consumed this cycle.
- io_in[7]  input  1  ack: host accepts the completed frame.
- io_out[0] output 1  res: registered result bit.
- io_out[1] output 1  bit_valid: res is new this cycle.
- io_out[2] output 1  busy: high in RUN.
- io_out[3] output 1  done: frame complete, result held.
- io_out[7:4] output 4  popcount of result bits in the current or last frame.
- Module ports are exactly io_in[7:0] and io_out[7:0]. Clock is io_in[0]; reset is io_in[1], synchronous and active-high.

Behaviour:
- Reset (sampled high on an edge):
  - state = IDLE; bit counter = 0; popcount = 0.
  - All io_out = 0.
  - Reset overrides every other input, including mid-frame; the partial frame is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN; bit counter and popcount clear to 0.
  - The start cycle carries no data.
  - popcount output keeps the last frame's value until start.
- RUN, busy=1:
  - hold=0: sample a,b,g. Next edge: res = (a^b)&g, bit_valid=1, counter+1, popcount += res.
  - hold=1: nothing sampled; bit_valid=0 next cycle; res keeps its value.
  - start is ignored; ack is ignored.
  - When the WIDTH-th bit is consumed -> DONE on the same edge its result registers.
  - res/bit_valid for the last bit appear together with done=1.
- Latency: one cycle from sample edge to res/bit_valid. A frame takes WIDTH + stall cycles after the start cycle.
- DONE:
  - done=1, busy=0, bit_valid=0 (from the cycle after the last bit); popcount and res held.
  - ack=1, start=0 -> IDLE; done=0 next cycle.
  - ack=1, start=1 -> RUN directly; counters clear.
  - start without ack is ignored.
- popcount width 4 bits: WIDTH ≤ 15 guarantees no overflow.
- Inputs are assumed synchronous to io_in[0]; no internal synchronisers.

Optional Feature:
- Macro XOR_AND_SEQ_PARITY_EN.
- Defined:
  - io_out[7] = running parity (XOR of all result bits) of the current or last frame; clears with popcount.
  - io_out[6:4] = popcount modulo 8.
- Undefined:
  - io_out[7:4] = full 4-bit popcount.
  - No parity logic is synthesised.

Test Plan:
- Reset mid-frame: start, 2 bits consumed, reset high 1 cycle -> next cycle io_out = 8'h00, state IDLE; a following start runs a full frame.
- WIDTH=4 frame: a bits 1,1,0,1; b bits 0,1,1,0; g bits 1,1,1,1 -> res 1,0,1,1 on consecutive cycles with bit_valid=1; done=1 with the last bit; io_out[7:4]=3.
- Gating: same a,b; g bits 0,0,1,1 -> res 0,0,1,1; popcount=2.
- Stall: hold=1 for 3 cycles before bit 2 -> bit_valid=0 for those 3 cycles; result sequence unchanged; done arrives 3 cycles later; busy high throughout.
- Done/ack handshake:
  - No ack for 5 cycles with start pulsed -> done stays 1, popcount stable, no new frame.
  - ack alone -> done=0 next cycle, popcount retained.
  - Repeat with ack+start together -> busy=1 next cycle, popcount=0.
- WIDTH=15, a=1, b=0, g=1 every bit:
  - Without the macro -> io_out[7:4]=4'hF.
  - With XOR_AND_SEQ_PARITY_EN -> io_out[7]=1, io_out[6:4]=7.
